// File: rtl/frac_div_pkg.sv
// Shared types and constants for the fractional clock-enable divider.
package frac_div_pkg;

  localparam int unsigned W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    PEND,
    RUN
  } state_t;

  // The remainder accumulator needs one extra bit to hold acc + R.
  function automatic int unsigned acc_w(input int unsigned w);
    return w + 1;
  endfunction

endpackage

// File: rtl/frac_div_ctrl_if.sv
// Ratio request channel: valid/ready handshake plus reject strobe.
interface frac_div_ctrl_if
  import frac_div_pkg::*;
#(
  parameter int unsigned W = W_DEF
) ();

  logic         cfg_valid;
  logic         cfg_ready;
  logic [W-1:0] cfg_src;
  logic [W-1:0] cfg_dst;
  logic         cfg_err;

  modport master (
    output cfg_valid, cfg_src, cfg_dst,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_src, cfg_dst,
    output cfg_ready, cfg_err
  );

endinterface

// File: rtl/frac_div_ctrl_seq_divider.sv
// Restoring divider: one quotient bit per cycle, fixed W-cycle latency.
module seq_divider
  import frac_div_pkg::*;
#(
  parameter int unsigned W = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);

  localparam int unsigned CW = $clog2(W + 1);

  logic [W-1:0]  dq;
  logic [W-1:0]  rem;
  logic [W-1:0]  dvs;
  logic [CW-1:0] cnt;
  logic [W:0]    trial;
  logic [W-1:0]  diff;
  logic          ge;

  // Trial subtraction of the divisor from the shifted partial remainder.
  always_comb begin
    trial = {rem, dq[W-1]};
    ge    = trial >= {1'b0, dvs};
    diff  = trial[W-1:0] - dvs;
  end

  // Shift-subtract iteration; done pulses on the edge of the last step.
  always_ff @(posedge clk) begin
    if (rst) begin
      dq   <= '0;
      rem  <= '0;
      dvs  <= '0;
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        dq  <= dividend;
        rem <= '0;
        dvs <= divisor;
        cnt <= CW'(W);
      end else if (cnt != '0) begin
        rem <= ge ? diff : trial[W-1:0];
        dq  <= {dq[W-2:0], ge};
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          done <= 1'b1;
        end
      end
    end
  end

  assign quotient  = dq;
  assign remainder = rem;

endmodule

// File: rtl/frac_div_ctrl.sv
// Fractional clock-enable sequencer: every DST periods span exactly SRC cycles.
module frac_div_ctrl
  import frac_div_pkg::*;
#(
  parameter int unsigned W       = W_DEF,
  parameter int unsigned DEF_SRC = 76
) (
  input  logic           clk,
  input  logic           rst,
  frac_div_ctrl_if.slave cfg,
  input  logic           stop,
  output logic           tick,
  output logic           tick_long,
  output logic           running,
  output logic [W-1:0]   cur_q,
  output logic [W-1:0]   cur_r
);

  localparam int unsigned AW = acc_w(W);

  if (DEF_SRC == 0) begin : g_def_src_chk
    $error("DEF_SRC must be non-zero");
  end

  state_t        state, state_nxt;
  logic          ready, req, bad, accept, reject, load, halt, boundary;
  logic          err_r, long_r, long_n;
  logic          div_done;
  logic [W-1:0]  div_q, div_r;
  logic [W-1:0]  dst_act, dst_nxt, cnt, last;
  logic [W-1:0]  dec_q, dec_r, dec_dst, last_n;
  logic [AW-1:0] acc, dec_acc, sum, acc_n;

  seq_divider #(.W(W)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (accept),
    .dividend  (cfg.cfg_src),
    .divisor   (cfg.cfg_dst),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );

  assign ready         = (state == IDLE) || (state == RUN);
  assign req           = cfg.cfg_valid && ready;
  assign bad           = (cfg.cfg_dst == '0) || (cfg.cfg_src < cfg.cfg_dst);
  assign boundary      = running && (cnt == last);
  assign tick          = boundary;
  assign tick_long     = boundary && long_r;
  assign cfg.cfg_ready = ready;
  assign cfg.cfg_err   = err_r;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and control strobes; a new ratio only lands on a tick edge
  // when something is already running, with stop taking priority there.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    reject    = 1'b0;
    load      = 1'b0;
    halt      = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (bad) reject = 1'b1;
          else begin
            accept    = 1'b1;
            state_nxt = DIV;
          end
        end
      end
      DIV: begin
        if (div_done) begin
          if (!running) begin
            load      = 1'b1;
            state_nxt = RUN;
          end else if (boundary && stop) begin
            halt      = 1'b1;
            state_nxt = IDLE;
          end else if (boundary) begin
            load      = 1'b1;
            state_nxt = RUN;
          end else begin
            state_nxt = PEND;
          end
        end
      end
      PEND: begin
        if (boundary) begin
          if (stop) begin
            halt      = 1'b1;
            state_nxt = IDLE;
          end else begin
            load      = 1'b1;
            state_nxt = RUN;
          end
        end
      end
      RUN: begin
        if (boundary && stop) begin
          halt      = 1'b1;
          state_nxt = IDLE;
        end
        if (req) begin
          if (bad) reject = 1'b1;
          else begin
            accept    = 1'b1;
            state_nxt = DIV;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Period decision: a load restarts the accumulator from zero with the new ratio.
  always_comb begin
    dec_q   = load ? div_q   : cur_q;
    dec_r   = load ? div_r   : cur_r;
    dec_dst = load ? dst_nxt : dst_act;
    dec_acc = load ? '0      : acc;
    sum     = dec_acc + AW'(dec_r);
    long_n  = sum >= AW'(dec_dst);
    acc_n   = long_n ? sum - AW'(dec_dst) : sum;
    last_n  = dec_q - W'(1) + W'(long_n);
  end

  // Ratio registers, accumulator and period counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_q   <= '0;
      cur_r   <= '0;
      dst_act <= '0;
      dst_nxt <= '0;
      acc     <= '0;
      cnt     <= '0;
      last    <= '0;
      long_r  <= 1'b0;
      running <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      err_r <= reject;
      if (accept) dst_nxt <= cfg.cfg_dst;
      if (load) begin
        cur_q   <= div_q;
        cur_r   <= div_r;
        dst_act <= dst_nxt;
        running <= 1'b1;
        cnt     <= '0;
        acc     <= acc_n;
        last    <= last_n;
        long_r  <= long_n;
      end else if (halt) begin
        running <= 1'b0;
        cnt     <= '0;
        long_r  <= 1'b0;
      end else if (boundary) begin
        cnt    <= '0;
        acc    <= acc_n;
        last   <= last_n;
        long_r <= long_n;
      end else if (running) begin
        cnt <= cnt + W'(1);
      end
    end
  end

endmodule

// File: tb/tb_frac_div_ctrl.sv
// Bench for frac_div_ctrl: directed plan items plus random ratios/stops
// checked every cycle against a period-arithmetic reference model.
module tb_frac_div_ctrl;

  localparam int unsigned W = 16;

  logic         clk  = 1'b0;
  logic         rst  = 1'b1;
  logic         stop = 1'b0;
  logic         tick, tick_long, running;
  logic [W-1:0] cur_q, cur_r;

  frac_div_ctrl_if #(.W(W)) cfg ();

  frac_div_ctrl #(.W(W), .DEF_SRC(76)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg       (cfg),
    .stop      (stop),
    .tick      (tick),
    .tick_long (tick_long),
    .running   (running),
    .cur_q     (cur_q),
    .cur_r     (cur_r)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  longint      cyc   = 0;
  int unsigned n_ticks = 0;

  // Reference model: absolute edge of the next tick, period index k since load.
  bit     m_run = 1'b0, m_busy = 1'b0, m_err = 1'b0;
  longint m_q = 0, m_r = 0, m_dst = 1, m_k = 0, m_next = 0, m_load_at = 0;
  longint p_q = 0, p_r = 0, p_dst = 1;

  // Period k is long exactly when floor(k*R/D) steps up.
  function automatic longint is_long(input longint k, input longint r, input longint d);
    return (k * r) / d - ((k - 1) * r) / d;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    longint e;
    bit     req, tick_now, exp_tick;
    longint s, d;
    e = cyc + 1;
    if (rst) begin
      m_run = 0; m_busy = 0; m_err = 0; m_q = 0; m_r = 0;
    end else begin
      req      = cfg.cfg_valid && !m_busy;
      tick_now = m_run && (m_next == e);
      m_err    = 0;
      if (m_busy && e >= m_load_at && (!m_run || tick_now)) begin
        m_busy = 0;
        if (m_run && stop) m_run = 0;
        else begin
          m_q = p_q; m_r = p_r; m_dst = p_dst; m_k = 1; m_run = 1;
          m_next = e + m_q + is_long(1, m_r, m_dst);
        end
      end else if (tick_now) begin
        if (stop && !m_busy) m_run = 0;
        else begin
          m_k++;
          m_next = e + m_q + is_long(m_k, m_r, m_dst);
        end
      end
      if (req) begin
        s = longint'(cfg.cfg_src);
        d = longint'(cfg.cfg_dst);
        if (d == 0 || s < d) m_err = 1;
        else begin
          m_busy = 1; m_load_at = e + W + 1;
          p_q = s / d; p_r = s % d; p_dst = d;
        end
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    exp_tick = m_run && (m_next == cyc + 1);
    if (tick === 1'b1) n_ticks++;
    check("tick", tick, exp_tick);
    check("tick_long", tick_long, exp_tick ? is_long(m_k, m_r, m_dst) : 0);
    check("running", running, m_run);
    check("cfg_ready", cfg.cfg_ready, !m_busy);
    check("cfg_err", cfg.cfg_err, m_err);
    check("cur_q", cur_q, m_q);
    check("cur_r", cur_r, m_r);
  endtask

  task automatic run(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step();
  endtask

  task automatic request(input int unsigned src, input int unsigned dst);
    cfg.cfg_src   = W'(src);
    cfg.cfg_dst   = W'(dst);
    cfg.cfg_valid = 1'b1;
    step();
    cfg.cfg_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    longint      t0, first;
    int unsigned hold, src, dst;
    cfg.cfg_valid = 1'b0;
    cfg.cfg_src   = '0;
    cfg.cfg_dst   = '0;
    run(3);
    rst = 1'b0;
    run(2);

    // 76/10 from idle: 7/6 ratio, 10 ticks per 76 cycles, first tick 7 after load.
    request(76, 10);
    run(W + 1);
    t0 = cyc;
    check("q_76_10", cur_q, 7);
    check("r_76_10", cur_r, 6);
    n_ticks = 0;
    first   = -1;
    for (int i = 0; i < 76; i++) begin
      step();
      if (first < 0 && tick === 1'b1) first = cyc;
    end
    check("first_tick_gap", first + 1 - t0, 7);
    check("ticks_per_window", n_ticks, 10);
    run(30);

    // Reconfigure to 10/3 while running.
    request(10, 3);
    run(70);
    check("q_10_3", cur_q, 3);

    // Rejects leave the running ratio alone.
    request(20, 0);
    check("err_dst0", cfg.cfg_err, 1);
    step();
    check("err_dst0_once", cfg.cfg_err, 0);
    request(5, 9);
    check("err_src_lt_dst", cfg.cfg_err, 1);
    step();
    check("err_src_lt_dst_once", cfg.cfg_err, 0);
    run(10);

    // 5/5: continuous ticks once loaded.
    request(5, 5);
    run(30);
    n_ticks = 0;
    run(20);
    check("ticks_5_5", n_ticks, 20);

    // 2/1 then stop mid-period: exactly one more tick.
    request(2, 1);
    run(30);
    for (int i = 0; i < 4 && tick === 1'b1; i++) step();
    stop    = 1'b1;
    n_ticks = 0;
    for (int i = 0; i < 6 && running === 1'b1; i++) step();
    stop = 1'b0;
    check("ticks_after_stop", n_ticks, 1);
    n_ticks = 0;
    run(10);
    check("ticks_when_stopped", n_ticks, 0);

    // Reset during divide.
    request(76, 10);
    run(7);
    rst = 1'b1;
    step();
    check("rst_div_running", running, 0);
    check("rst_div_ready", cfg.cfg_ready, 1);
    check("rst_div_q", cur_q, 0);
    rst     = 1'b0;
    n_ticks = 0;
    run(40);
    check("rst_div_no_tick", n_ticks, 0);

    // Random ratios, held valids, rejects and stops.
    for (int it = 0; it < 25; it++) begin
      dst  = $urandom_range(0, 8);
      src  = $urandom_range(0, 40);
      hold = $urandom_range(1, 3);
      cfg.cfg_src   = W'(src);
      cfg.cfg_dst   = W'(dst);
      cfg.cfg_valid = 1'b1;
      run(hold);
      cfg.cfg_valid = 1'b0;
      run($urandom_range(5, 40));
      if ($urandom_range(0, 3) == 0) begin
        stop = 1'b1;
        run($urandom_range(1, 12));
        stop = 1'b0;
      end
    end
    run(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
